// File: rtl/mem_stage_ws.sv
// MEM stage with byte-addressed data memory, B/H/W access sizing, misalignment
// suppression, configurable wait states and the MEM/WB pipeline register.
module mem_stage_ws #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [2:0]      Funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [4:0]      RdM,
  input  logic [XLEN-1:0] PCPlus4M,
  output logic            StallMem,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [4:0]      RdW,
  output logic [XLEN-1:0] PCPlus4W,
  output logic            MisalignW
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic       HAS_WAIT = (WAIT_STATES != 0);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  // Funct3[1:0] encodes size (00 B, 01 H, else W); bit 2 selects zero extension.
  function automatic logic isMisaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   isMisaligned = 1'b0;
      2'b01:   isMisaligned = off[0];
      default: isMisaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byteEnable(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   byteEnable = 4'b0001 << off;
      2'b01:   byteEnable = off[1] ? 4'b1100 : 4'b0011;
      default: byteEnable = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] storeLanes(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3[1:0])
      2'b00:   storeLanes = {4{d[7:0]}};
      2'b01:   storeLanes = {2{d[15:0]}};
      default: storeLanes = d;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] loadExtend(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   loadExtend = f3[2] ? {{(XLEN-8){1'b0}}, b} : {{(XLEN-8){b[7]}}, b};
      2'b01:   loadExtend = f3[2] ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
      default: loadExtend = word;
    endcase
  endfunction

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  state_t          state_r;
  logic [3:0]      cnt_r;
  logic            access_s;
  logic            isStore_s;
  logic            isLoad_s;
  logic            misalign_s;
  logic            stall_s;
  logic            commit_s;
  logic [1:0]      off_s;
  logic [AW-1:0]   idx_s;
  logic [3:0]      be_s;
  logic [XLEN-1:0] wdata_s;
  logic [XLEN-1:0] readWord_s;
  logic [XLEN-1:0] loadData_s;

  // Access decode, stall generation and load data extraction.
  always_comb begin
    access_s   = MemReadM | MemWriteM;
    isStore_s  = MemWriteM;
    isLoad_s   = MemReadM & ~MemWriteM;
    off_s      = ALUResultM[1:0];
    idx_s      = ALUResultM[AW+1:2];
    misalign_s = access_s & isMisaligned(Funct3M, off_s);
    be_s       = byteEnable(Funct3M, off_s);
    wdata_s    = storeLanes(Funct3M, WriteDataM);
    readWord_s = mem[idx_s];
    if (state_r == WAIT) begin
      stall_s = (cnt_r != 4'd0);
    end else begin
      stall_s = access_s & HAS_WAIT;
    end
    commit_s = isStore_s & ~misalign_s & ~stall_s;
    if (isLoad_s && !misalign_s) begin
      loadData_s = loadExtend(Funct3M, off_s, readWord_s);
    end else begin
      loadData_s = {XLEN{1'b0}};
    end
  end

  assign StallMem = stall_s;

  // Data memory: byte-lane writes on the completion edge; contents are not reset.
  always_ff @(posedge clk) begin
    if (!reset && commit_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  // Wait-state FSM and MEM/WB register; stalled cycles push a bubble into W.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= {XLEN{1'b0}};
      ReadDataW  <= {XLEN{1'b0}};
      RdW        <= 5'd0;
      PCPlus4W   <= {XLEN{1'b0}};
      MisalignW  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (access_s && HAS_WAIT) begin
            state_r <= WAIT;
            cnt_r   <= CNT_INIT;
          end else begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
          end
        end
        WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
        end
      endcase

      if (stall_s) begin
        RegWriteW  <= 1'b0;
        ResultSrcW <= 2'b00;
        ALUResultW <= {XLEN{1'b0}};
        ReadDataW  <= {XLEN{1'b0}};
        RdW        <= 5'd0;
        PCPlus4W   <= {XLEN{1'b0}};
        MisalignW  <= 1'b0;
      end else begin
        RegWriteW  <= RegWriteM;
        ResultSrcW <= ResultSrcM;
        ALUResultW <= ALUResultM;
        ReadDataW  <= loadData_s;
        RdW        <= RdM;
        PCPlus4W   <= PCPlus4M;
        MisalignW  <= misalign_s;
      end
    end
  end

endmodule
